// File: rtl/sbinit_handshake_ctrl.sv
// SBINIT sideband handshake sequencer: pattern request, OUT_OF_RESET exchange,
// DONE_REQ/DONE_RESP exchange, with an optional cycle-count timeout.
module sbinit_handshake_ctrl #(
    parameter int SB_MSG_WIDTH = 4,
    parameter int TIMEOUT_W    = 20
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [TIMEOUT_W-1:0]    i_timeout_limit,
    input  logic                    i_pattern_done,
    input  logic                    i_sb_busy,
    input  logic                    i_rx_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_sb_msg,
    output logic                    o_pattern_req,
    output logic                    o_tx_valid,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_sb_msg,
    output logic                    o_done,
    output logic                    o_timeout
);
    // Bit index of each message in the flag vectors; wire code is index + 1.
    localparam int NUM_MSG  = 3;
    localparam int IDX_OOR  = 0;
    localparam int IDX_REQ  = 1;
    localparam int IDX_RESP = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PATTERN,
        S_OOR,
        S_XCHG,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t               state_reg, state_next;
    logic [NUM_MSG-1:0]   rcvd_reg, rcvd_next;
    logic [NUM_MSG-1:0]   sent_reg, sent_next;
    logic [TIMEOUT_W-1:0] count_reg, count_next;
    logic                 pattern_req_reg, done_reg, timeout_reg;

    logic [NUM_MSG-1:0]      rx_hit, pend, send;
    logic [SB_MSG_WIDTH-1:0] tx_code;
    logic [TIMEOUT_W:0]      count_plus;
    logic                    active, tx_allowed, timeout_hit, oor_cond, done_cond;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MSG; gi++) begin : g_rx
            assign rx_hit[gi] = i_rx_valid && (i_decoded_sb_msg == SB_MSG_WIDTH'(gi + 1));
        end
    endgenerate

    // The send queue is implied by state plus sent/received flags: each message
    // is pending from the moment its trigger holds until it has gone out once.
    always_comb begin
        pend           = '0;
        pend[IDX_OOR]  = (state_reg == S_OOR)  && !sent_reg[IDX_OOR];
        pend[IDX_REQ]  = (state_reg == S_XCHG) && !sent_reg[IDX_REQ];
        pend[IDX_RESP] = (state_reg == S_XCHG) && rcvd_reg[IDX_REQ] && !sent_reg[IDX_RESP];
    end

    assign tx_allowed = i_en && !i_rst && !i_sb_busy;

    always_comb begin
        send = '0;
        if (tx_allowed) begin
            if (pend[IDX_RESP])
                send[IDX_RESP] = 1'b1;
            else if (pend[IDX_OOR])
                send[IDX_OOR] = 1'b1;
            else if (pend[IDX_REQ])
                send[IDX_REQ] = 1'b1;
        end
    end

    always_comb begin
        tx_code = '0;
        for (int i = 0; i < NUM_MSG; i++) begin
            if (send[i])
                tx_code = SB_MSG_WIDTH'(i + 1);
        end
    end

    assign o_tx_valid       = |send;
    assign o_encoded_sb_msg = tx_code;

    assign active      = (state_reg == S_PATTERN) || (state_reg == S_OOR) || (state_reg == S_XCHG);
    assign count_plus  = {1'b0, count_reg} + (TIMEOUT_W + 1)'(1);
    assign timeout_hit = active && (i_timeout_limit != '0) && (count_plus >= {1'b0, i_timeout_limit});

    // Same-cycle sends and receptions count, so progress never waits an extra cycle.
    assign oor_cond  = (sent_reg[IDX_OOR] || send[IDX_OOR]) &&
                       (rcvd_reg[IDX_OOR] || rx_hit[IDX_OOR]);
    // Our own DONE_REQ must also be out, otherwise the partner may never answer it.
    assign done_cond = (sent_reg[IDX_REQ]  || send[IDX_REQ])  &&
                       (sent_reg[IDX_RESP] || send[IDX_RESP]) &&
                       (rcvd_reg[IDX_RESP] || rx_hit[IDX_RESP]);

    always_comb begin
        state_next = state_reg;
        sent_next  = sent_reg | send;
        rcvd_next  = (state_reg != S_IDLE) ? (rcvd_reg | rx_hit) : rcvd_reg;
        count_next = count_reg;
        if (active && (count_reg != '1))
            count_next = count_plus[TIMEOUT_W-1:0];

        case (state_reg)
            S_IDLE: begin
                sent_next  = '0;
                rcvd_next  = '0;
                count_next = '0;
                if (i_en)
                    state_next = S_PATTERN;
            end
            S_PATTERN: begin
                if (i_pattern_done)
                    state_next = S_OOR;
                else if (timeout_hit)
                    state_next = S_TIMEOUT;
            end
            S_OOR: begin
                if (oor_cond)
                    state_next = S_XCHG;
                else if (timeout_hit)
                    state_next = S_TIMEOUT;
            end
            S_XCHG: begin
                if (done_cond)
                    state_next = S_DONE;
                else if (timeout_hit)
                    state_next = S_TIMEOUT;
            end
            default: state_next = state_reg;
        endcase

        if (!i_en) begin
            state_next = S_IDLE;
            sent_next  = '0;
            rcvd_next  = '0;
            count_next = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg       <= S_IDLE;
            sent_reg        <= '0;
            rcvd_reg        <= '0;
            count_reg       <= '0;
            pattern_req_reg <= 1'b0;
            done_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sent_reg        <= sent_next;
            rcvd_reg        <= rcvd_next;
            count_reg       <= count_next;
            pattern_req_reg <= (state_next == S_PATTERN);
            done_reg        <= (state_next == S_DONE);
            timeout_reg     <= (state_next == S_TIMEOUT);
        end
    end

    assign o_pattern_req = pattern_req_reg;
    assign o_done        = done_reg;
    assign o_timeout     = timeout_reg;

endmodule
